// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the ALU control decoder and the
// multi-cycle ALU execution block.
//   alu_ctl_e   : 3-bit ALU control code produced by the decoder
//   FUNCT_*     : R-type function codes understood by the decoder
//   ALU_OP_*    : main-control alu_op encodings
//   alu_state_e : execution FSM states (IDLE -> EXEC -> DONE)
package alu_pkg;

    typedef enum logic [2:0] {
        CTL_AND     = 3'b000,
        CTL_OR      = 3'b001,
        CTL_ADD     = 3'b010,
        CTL_MUL     = 3'b011,
        CTL_ROL     = 3'b100,
        CTL_ROR     = 3'b101,
        CTL_SUB     = 3'b110,
        CTL_ILLEGAL = 3'b111
    } alu_ctl_e;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_ROL = 6'b100001;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_ROR = 6'b100011;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_MUL = 6'b011000;

    localparam logic [1:0] ALU_OP_ADD = 2'b00;
    localparam logic [1:0] ALU_OP_SUB = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } alu_state_e;

endpackage

// File: rtl/alu_ctl_decode.sv
// alu_ctl_decode: combinational ALU control decoder, shared with the main
// control unit.
//   alu_op [1:0] : 00 = ADD (loads/stores), 01 = SUB (branch compare),
//                  1x = R-type, operation taken from funct
//   funct  [5:0] : R-type function code
//   ctl          : decoded alu_ctl_e; unknown functs give CTL_ILLEGAL
// Build option: ALU_MULT_EN makes funct 011000 decode to CTL_MUL; without it
// that code is illegal like any other unsupported funct.
module alu_ctl_decode
    import alu_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output alu_ctl_e   ctl
);

    always_comb begin
        ctl = CTL_ILLEGAL;
        case (alu_op)
            ALU_OP_ADD: ctl = CTL_ADD;
            ALU_OP_SUB: ctl = CTL_SUB;
            default: begin
                case (funct)
                    FUNCT_ADD: ctl = CTL_ADD;
                    FUNCT_ROL: ctl = CTL_ROL;
                    FUNCT_SUB: ctl = CTL_SUB;
                    FUNCT_ROR: ctl = CTL_ROR;
                    FUNCT_AND: ctl = CTL_AND;
                    FUNCT_OR:  ctl = CTL_OR;
`ifdef ALU_MULT_EN
                    FUNCT_MUL: ctl = CTL_MUL;
`endif
                    default:   ctl = CTL_ILLEGAL;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/alu_exec_seq.sv
// alu_exec_seq: multi-cycle ALU between control/register file and writeback.
// Decodes alu_op/funct, executes on WIDTH-bit operands, returns result+flags.
//   clk, rst_n            : clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready     : request handshake; alu_op, funct, op_a, op_b, shamt
//                           are captured on the accepting edge
//   out_valid/out_ready   : result handshake; result, zero, ovf, illegal
//   dbg_state             : current FSM state, for observation only
// Handshake rule (both sides): a transfer occurs at a rising edge where
// valid && ready are both 1. out_valid and the result/flags stay stable until
// that transfer; in_ready is high in IDLE, and in DONE whenever out_ready is
// high, so a new request can be taken on the same edge the result drains.
// Rotates run one bit per EXEC cycle (shamt = 0 still spends one cycle).
// Build option: ALU_MULT_EN adds an iterative shift-add multiplier (WIDTH EXEC
// cycles, low product half returned, ovf when the high half is nonzero).
module alu_exec_seq
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         alu_op,
    input  logic [5:0]         funct,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               ovf,
    output logic               illegal,
    output alu_state_e         dbg_state
);

    // One extra bit so the multiplier's WIDTH iteration count fits.
    localparam int CNT_W = SHAMT_W + 1;

    alu_state_e       state_q, state_d;
    alu_ctl_e         ctl_dec, ctl_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q, ovf_q, illegal_q;

    logic             accept;
    logic             exec_last;
    logic [WIDTH-1:0] sum, diff, rot;
    logic [WIDTH-1:0] exec_res;
    logic             exec_ovf, exec_ill;

    alu_ctl_decode u_decode (
        .alu_op (alu_op),
        .funct  (funct),
        .ctl    (ctl_dec)
    );

    assign accept    = in_valid && in_ready;
    assign result    = result_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;
    assign illegal   = illegal_q;
    assign dbg_state = state_q;

`ifdef ALU_MULT_EN
    localparam logic [CNT_W-1:0] MUL_ITERS = CNT_W'(WIDTH);

    // Right-shifting product register: upper half accumulates, lower half
    // starts as the multiplier and is consumed one bit per cycle.
    logic [2*WIDTH-1:0] prod_q, prod_step;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     hi_sum;

    always_comb begin
        addend    = prod_q[0] ? a_q : {WIDTH{1'b0}};
        hi_sum    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        prod_step = {hi_sum, prod_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
        end else if (accept) begin
            prod_q <= {{WIDTH{1'b0}}, op_b};
        end else if (state_q == EXEC && ctl_q == CTL_MUL) begin
            prod_q <= prod_step;
        end
    end
`endif

    // Last EXEC cycle of the current operation.
    always_comb begin
        case (ctl_q)
            CTL_ROL, CTL_ROR: exec_last = (cnt_q <= CNT_W'(1));
`ifdef ALU_MULT_EN
            CTL_MUL:          exec_last = (cnt_q == CNT_W'(1));
`endif
            default:          exec_last = 1'b1;
        endcase
    end

    // FSM next state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = EXEC;
            end
            EXEC: begin
                if (exec_last) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) state_d = in_valid ? EXEC : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Datapath for the final EXEC cycle.
    always_comb begin
        sum      = a_q + b_q;
        diff     = a_q - b_q;
        rot      = (ctl_q == CTL_ROL) ? {a_q[WIDTH-2:0], a_q[WIDTH-1]}
                                      : {a_q[0], a_q[WIDTH-1:1]};
        exec_res = '0;
        exec_ovf = 1'b0;
        exec_ill = 1'b0;
        case (ctl_q)
            CTL_AND: exec_res = a_q & b_q;
            CTL_OR:  exec_res = a_q | b_q;
            CTL_ADD: begin
                exec_res = sum;
                exec_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            CTL_SUB: begin
                exec_res = diff;
                exec_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
            end
            // A zero rotate amount finishes in one cycle with A unchanged.
            CTL_ROL, CTL_ROR: exec_res = (cnt_q == '0) ? a_q : rot;
`ifdef ALU_MULT_EN
            CTL_MUL: begin
                exec_res = prod_step[WIDTH-1:0];
                exec_ovf = |prod_step[2*WIDTH-1:WIDTH];
            end
`endif
            default: exec_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctl_q     <= CTL_ILLEGAL;
            a_q       <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else if (accept) begin
            ctl_q <= ctl_dec;
            a_q   <= op_a;
            b_q   <= op_b;
`ifdef ALU_MULT_EN
            cnt_q <= (ctl_dec == CTL_MUL) ? MUL_ITERS : {1'b0, shamt};
`else
            cnt_q <= {1'b0, shamt};
`endif
        end else if (state_q == EXEC) begin
            if (ctl_q == CTL_ROL || ctl_q == CTL_ROR) a_q <= rot;
            if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
            if (exec_last) begin
                result_q  <= exec_res;
                zero_q    <= (exec_res == '0);
                ovf_q     <= exec_ovf;
                illegal_q <= exec_ill;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_seq.sv
// Directed bench for alu_exec_seq (WIDTH = 32). Each scenario task drives its
// own vectors and compares against hand-computed values.
module tb_alu_exec_seq;
    import alu_pkg::*;

    localparam int W  = 32;
    localparam int SW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    alu_op = '0;
    logic [5:0]    funct = '0;
    logic [W-1:0]  op_a = '0;
    logic [W-1:0]  op_b = '0;
    logic [SW-1:0] shamt = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  result;
    logic          zero, ovf, illegal;
    alu_state_e    dbg_state;

    int vectors = 0;
    int miscompares = 0;
    logic [W-1:0] exp_q[$];

    alu_exec_seq #(.WIDTH(W), .SHAMT_W(SW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct(funct), .op_a(op_a), .op_b(op_b), .shamt(shamt),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .ovf(ovf), .illegal(illegal), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_inputs();
        alu_op = 2'($urandom_range(0, 3));
        funct  = 6'($urandom_range(0, 63));
        op_a   = $urandom;
        op_b   = $urandom;
        shamt  = SW'($urandom_range(0, 31));
    endtask

    // Presents one request, waits for its acceptance, then scrambles inputs.
    task automatic send(input logic [1:0] op, input logic [5:0] f, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [SW-1:0] sh);
        int n = 0;
        alu_op = op; funct = f; op_a = a; op_b = b; shamt = sh;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            vectors++; miscompares++;
            $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        scramble_inputs();
    endtask

    // Counts edges from the accept edge (counted as 1) until out_valid.
    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
        if (!out_valid) begin
            vectors++; miscompares++;
            $display("FAIL result_timeout: out_valid=%0b required 1 after %0d cycles", out_valid, lat);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            scramble_inputs();
            tick();
        end
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset_out_valid: got %0b required 0", out_valid);
        end
        vectors++;
        if (result !== '0 || zero !== 1'b0 || ovf !== 1'b0 || illegal !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got result=%h zero=%0b ovf=%0b illegal=%0b required all 0",
                     result, zero, ovf, illegal);
        end
        vectors++;
        if (dbg_state !== IDLE) begin
            miscompares++; $display("FAIL reset_state: got %0d required %0d", dbg_state, IDLE);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        rst_n = 1'b1;
        tick();
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++; $display("FAIL reset_in_ready: got %0b required 1", in_ready);
        end
    endtask

    task automatic test_add();
        int lat;
        send(2'b00, 6'h00, 32'h7FFF_FFFF, 32'h0000_0001, '0);
        wait_out(lat);
        vectors++;
        if (result !== 32'h8000_0000 || ovf !== 1'b1 || zero !== 1'b0 || illegal !== 1'b0) begin
            miscompares++;
            $display("FAIL add_ovf: got r=%h ovf=%0b z=%0b ill=%0b required r=80000000 ovf=1 z=0 ill=0",
                     result, ovf, zero, illegal);
        end
        vectors++;
        if (lat !== 2) begin
            miscompares++; $display("FAIL add_latency: got %0d required 2", lat);
        end
        tick();
        send(2'b10, FUNCT_ADD, 32'd5, 32'd3, '0);
        wait_out(lat);
        vectors++;
        if (result !== 32'd8 || ovf !== 1'b0 || zero !== 1'b0) begin
            miscompares++; $display("FAIL add_rtype: got r=%h ovf=%0b z=%0b required r=8 ovf=0 z=0", result, ovf, zero);
        end
        tick();
        send(2'b00, 6'h3F, 32'h8000_0000, 32'h8000_0000, '0);
        wait_out(lat);
        vectors++;
        if (result !== 32'h0 || ovf !== 1'b1 || zero !== 1'b1) begin
            miscompares++; $display("FAIL add_neg_ovf: got r=%h ovf=%0b z=%0b required r=0 ovf=1 z=1", result, ovf, zero);
        end
        tick();
    endtask

    task automatic test_sub();
        int lat;
        send(2'b01, 6'h00, 32'h0000_1234, 32'h0000_1234, '0);
        wait_out(lat);
        vectors++;
        if (result !== 32'h0 || zero !== 1'b1 || ovf !== 1'b0) begin
            miscompares++; $display("FAIL sub_zero: got r=%h z=%0b ovf=%0b required r=0 z=1 ovf=0", result, zero, ovf);
        end
        tick();
        send(2'b01, 6'h00, 32'h8000_0000, 32'h0000_0001, '0);
        wait_out(lat);
        vectors++;
        if (result !== 32'h7FFF_FFFF || ovf !== 1'b1) begin
            miscompares++; $display("FAIL sub_ovf: got r=%h ovf=%0b required r=7fffffff ovf=1", result, ovf);
        end
        tick();
        send(2'b10, FUNCT_SUB, 32'd5, 32'd7, '0);
        wait_out(lat);
        vectors++;
        if (result !== 32'hFFFF_FFFE || ovf !== 1'b0 || zero !== 1'b0) begin
            miscompares++; $display("FAIL sub_rtype: got r=%h ovf=%0b required r=fffffffe ovf=0", result, ovf);
        end
        tick();
    endtask

    task automatic test_logic();
        int lat;
        send(2'b10, FUNCT_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, '0);
        wait_out(lat);
        vectors++;
        if (result !== 32'hF000_F000 || zero !== 1'b0 || ovf !== 1'b0) begin
            miscompares++; $display("FAIL and: got r=%h required f000f000", result);
        end
        tick();
        send(2'b11, FUNCT_OR, 32'hF0F0_F0F0, 32'hFF00_FF00, '0);
        wait_out(lat);
        vectors++;
        if (result !== 32'hFFF0_FFF0) begin
            miscompares++; $display("FAIL or: got r=%h required fff0fff0", result);
        end
        tick();
        send(2'b10, FUNCT_AND, 32'h0000_000F, 32'h0000_00F0, '0);
        wait_out(lat);
        vectors++;
        if (result !== 32'h0 || zero !== 1'b1) begin
            miscompares++; $display("FAIL and_zero: got r=%h z=%0b required r=0 z=1", result, zero);
        end
        tick();
    endtask

    task automatic test_rotate();
        int lat;
        send(2'b10, FUNCT_ROL, 32'h8000_0001, '0, 5'd4);
        wait_out(lat);
        vectors++;
        if (result !== 32'h0000_0018 || lat !== 5) begin
            miscompares++; $display("FAIL rol4: got r=%h lat=%0d required r=00000018 lat=5", result, lat);
        end
        tick();
        send(2'b10, FUNCT_ROL, 32'h8000_0001, '0, 5'd0);
        wait_out(lat);
        vectors++;
        if (result !== 32'h8000_0001 || lat !== 2) begin
            miscompares++; $display("FAIL rol0: got r=%h lat=%0d required r=80000001 lat=2", result, lat);
        end
        tick();
        send(2'b10, FUNCT_ROR, 32'h8000_0001, '0, 5'd1);
        wait_out(lat);
        vectors++;
        if (result !== 32'hC000_0000 || lat !== 2) begin
            miscompares++; $display("FAIL ror1: got r=%h lat=%0d required r=c0000000 lat=2", result, lat);
        end
        tick();
        send(2'b10, FUNCT_ROR, 32'h0000_0001, '0, 5'd31);
        wait_out(lat);
        vectors++;
        if (result !== 32'h0000_0002 || lat !== 32 || ovf !== 1'b0) begin
            miscompares++; $display("FAIL ror31: got r=%h lat=%0d required r=00000002 lat=32", result, lat);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [W-1:0] exp;
        out_ready = 1'b0;
        exp_q.push_back(32'd3);
        exp_q.push_back(32'd6);
        send(2'b00, 6'h00, 32'd1, 32'd2, '0);
        wait_out(lat);
        exp = exp_q.pop_front();
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (out_valid !== 1'b1 || result !== exp || in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL hold_%0d: got v=%0b r=%h in_ready=%0b required v=1 r=%h in_ready=0",
                         i, out_valid, result, in_ready, exp);
            end
            tick();
        end
        alu_op = 2'b01; funct = 6'h00; op_a = 32'd10; op_b = 32'd4; shamt = '0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++; $display("FAIL b2b_ready: got %0b required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        scramble_inputs();
        vectors++;
        if (dbg_state !== EXEC || out_valid !== 1'b0) begin
            miscompares++; $display("FAIL b2b_no_bubble: got state=%0d v=%0b required state=%0d v=0",
                                    dbg_state, out_valid, EXEC);
        end
        wait_out(lat);
        exp = exp_q.pop_front();
        vectors++;
        if (result !== exp || lat !== 2) begin
            miscompares++; $display("FAIL b2b_second: got r=%h lat=%0d required r=%h lat=2", result, lat, exp);
        end
        tick();
    endtask

    task automatic test_illegal();
        int lat;
        send(2'b10, 6'b111111, 32'hDEAD_BEEF, 32'h1234_5678, '0);
        wait_out(lat);
        vectors++;
        if (illegal !== 1'b1 || result !== '0 || zero !== 1'b1 || ovf !== 1'b0) begin
            miscompares++; $display("FAIL illegal: got ill=%0b r=%h z=%0b ovf=%0b required ill=1 r=0 z=1 ovf=0",
                                    illegal, result, zero, ovf);
        end
        tick();
        vectors++;
        if (dbg_state !== IDLE || out_valid !== 1'b0) begin
            miscompares++; $display("FAIL illegal_drain: got state=%0d v=%0b required state=%0d v=0",
                                    dbg_state, out_valid, IDLE);
        end
        send(2'b10, FUNCT_MUL, 32'd6, 32'd7, '0);
        wait_out(lat);
`ifdef ALU_MULT_EN
        vectors++;
        if (result !== 32'd42 || illegal !== 1'b0 || ovf !== 1'b0 || lat !== W + 1) begin
            miscompares++; $display("FAIL mul: got r=%h ill=%0b ovf=%0b lat=%0d required r=2a ill=0 ovf=0 lat=%0d",
                                    result, illegal, ovf, lat, W + 1);
        end
        tick();
        send(2'b10, FUNCT_MUL, 32'h0001_0000, 32'h0001_0000, '0);
        wait_out(lat);
        vectors++;
        if (result !== 32'h0 || ovf !== 1'b1 || zero !== 1'b1) begin
            miscompares++; $display("FAIL mul_ovf: got r=%h ovf=%0b required r=0 ovf=1", result, ovf);
        end
`else
        vectors++;
        if (illegal !== 1'b1 || result !== '0 || lat !== 2) begin
            miscompares++; $display("FAIL mul_disabled: got ill=%0b r=%h lat=%0d required ill=1 r=0 lat=2",
                                    illegal, result, lat);
        end
`endif
        tick();
    endtask

    task automatic test_abort();
        int lat;
        bit seen = 1'b0;
        send(2'b10, FUNCT_ROR, 32'h0000_00FF, '0, 5'd10);
        tick();
        tick();
        rst_n = 1'b0;
        #2;
        vectors++;
        if (dbg_state !== IDLE || out_valid !== 1'b0 || result !== '0) begin
            miscompares++; $display("FAIL abort_reset: got state=%0d v=%0b r=%h required state=%0d v=0 r=0",
                                    dbg_state, out_valid, result, IDLE);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++; $display("FAIL abort_no_result: got out_valid seen=%0b required 0", seen);
        end
        send(2'b00, 6'h00, 32'd100, 32'd23, '0);
        wait_out(lat);
        vectors++;
        if (result !== 32'd123 || lat !== 2) begin
            miscompares++; $display("FAIL abort_recover: got r=%h lat=%0d required r=7b lat=2", result, lat);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_rotate();
        test_back_to_back();
        test_illegal();
        test_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
